// File: rtl/encoder_rr_8x3.sv
// Round-robin priority encoder with a one-entry registered output slot.
// Grants the first set request at or above the rotating pointer and counts handshakes.
module encoder_rr_8x3 #(
   parameter int INPUT_WIDTH   = 8,
   parameter int OUTPUT_LENGTH = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [INPUT_WIDTH-1:0]   req_i,
   input  logic                     enable_i,
   input  logic                     out_ready_i,
   output logic [OUTPUT_LENGTH-1:0] out_o,
   output logic                     valid_o,
   output logic                     multi_o,
   output logic [7:0]               grant_count_o
);

   localparam logic [OUTPUT_LENGTH-1:0] PTR_ONE = {{(OUTPUT_LENGTH-1){1'b0}}, 1'b1};
   localparam logic [INPUT_WIDTH-1:0]   REQ_ONE = {{(INPUT_WIDTH-1){1'b0}}, 1'b1};

   logic [OUTPUT_LENGTH-1:0] r_out;
   logic                     r_valid;
   logic                     r_multi;
   logic [7:0]               r_count;
   logic [OUTPUT_LENGTH-1:0] r_ptr;

   logic                     w_slot_free;
   logic                     w_capture;
   logic                     w_handshake;
   logic                     w_found;
   logic [OUTPUT_LENGTH-1:0] w_sel;
   logic [OUTPUT_LENGTH-1:0] w_scan_idx;
   logic [OUTPUT_LENGTH-1:0] w_out_nxt;
   logic                     w_valid_nxt;
   logic                     w_multi_nxt;
   logic [7:0]               w_count_nxt;
   logic [OUTPUT_LENGTH-1:0] w_ptr_nxt;

   assign w_slot_free = ~r_valid | out_ready_i;
   assign w_capture   = w_slot_free & enable_i & (|req_i);
   assign w_handshake = r_valid & out_ready_i;

   // Circular scan upward from the pointer; index arithmetic wraps at the power-of-two width.
   always_comb begin
      w_found    = 1'b0;
      w_sel      = r_ptr;
      w_scan_idx = r_ptr;
      for (int k = 0; k < INPUT_WIDTH; k++) begin
         w_scan_idx = r_ptr + OUTPUT_LENGTH'(k);
         if (!w_found && req_i[w_scan_idx]) begin
            w_found = 1'b1;
            w_sel   = w_scan_idx;
         end else begin
            w_found = w_found;
            w_sel   = w_sel;
         end
      end
   end

   // Next-state selection for the output slot, pointer and handshake counter.
   always_comb begin
      w_out_nxt   = r_out;
      w_valid_nxt = r_valid;
      w_multi_nxt = r_multi;
      w_ptr_nxt   = r_ptr;
      if (w_capture) begin
         w_out_nxt   = w_sel;
         w_valid_nxt = 1'b1;
         w_multi_nxt = |(req_i & (req_i - REQ_ONE));
         w_ptr_nxt   = w_sel + PTR_ONE;
      end else if (w_slot_free) begin
         w_valid_nxt = 1'b0;
      end else begin
         w_valid_nxt = r_valid;
      end
      if (w_handshake) begin
         w_count_nxt = r_count + 8'd1;
      end else begin
         w_count_nxt = r_count;
      end
   end

   // State registers; reset drops any pending result without counting it.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_out   <= '0;
         r_valid <= 1'b0;
         r_multi <= 1'b0;
         r_count <= 8'd0;
         r_ptr   <= '0;
      end else begin
         r_out   <= w_out_nxt;
         r_valid <= w_valid_nxt;
         r_multi <= w_multi_nxt;
         r_count <= w_count_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign out_o         = r_out;
   assign valid_o       = r_valid;
   assign multi_o       = r_multi;
   assign grant_count_o = r_count;

endmodule

// File: tb/tb_encoder_rr_8x3.sv
// Self-checking bench for encoder_rr_8x3: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_encoder_rr_8x3;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       en;
   logic       rdy;
   logic [2:0] out;
   logic       valid;
   logic       multi;
   logic [7:0] cnt;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   int m_out, m_valid, m_multi, m_cnt, m_ptr;

   encoder_rr_8x3 #(.INPUT_WIDTH(8), .OUTPUT_LENGTH(3)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .enable_i(en),
      .out_ready_i(rdy), .out_o(out), .valid_o(valid), .multi_o(multi),
      .grant_count_o(cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++)
         if (r[(p + k) % 8]) return (p + k) % 8;
      return p;
   endfunction

   function automatic int ones(input logic [7:0] r);
      int n = 0;
      for (int i = 0; i < 8; i++) n += r[i];
      return n;
   endfunction

   // Reference model: one result slot, rotating pointer, handshake counter.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_out <= 0; m_valid <= 0; m_multi <= 0; m_cnt <= 0; m_ptr <= 0;
      end else begin
         if (m_valid == 1 && rdy) m_cnt <= (m_cnt + 1) % 256;
         if ((m_valid == 0 || rdy) && en && req != 8'd0) begin
            m_out   <= pick(req, m_ptr);
            m_ptr   <= (pick(req, m_ptr) + 1) % 8;
            m_valid <= 1;
            m_multi <= (ones(req) > 1) ? 1 : 0;
         end else if (m_valid == 0 || rdy) begin
            m_valid <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_valid", valid, m_valid);
         chk("model_out",   out,   m_out);
         chk("model_multi", multi, m_multi);
         chk("model_count", cnt,   m_cnt);
      end
   end

   task automatic step(input logic [7:0] r, input logic e, input logic y);
      req = r; en = e; rdy = y;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      req = 8'd0; en = 1'b0; rdy = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int c0;
      rst_n = 1'b0; req = 8'd0; en = 1'b0; rdy = 1'b0;
      @(negedge clk);
      do_reset();
      chk_on = 1'b1;
      chk("rst_out", out, 0); chk("rst_valid", valid, 0);
      chk("rst_multi", multi, 0); chk("rst_cnt", cnt, 0);

      // Single request, then pointer sits just above it.
      step(8'b0000_0100, 1'b1, 1'b1);
      chk("single_out", out, 2); chk("single_valid", valid, 1); chk("single_multi", multi, 0);
      step(8'h00, 1'b1, 1'b1);
      chk("single_cnt", cnt, 1); chk("single_idle", valid, 0);
      step(8'hFF, 1'b1, 1'b1);
      chk("ptr3_out", out, 3); chk("ptr3_multi", multi, 1);

      // Round-robin between bits 0 and 7.
      do_reset();
      step(8'b1000_0001, 1'b1, 1'b1); chk("rr0", out, 0); chk("rr0_multi", multi, 1);
      step(8'b1000_0001, 1'b1, 1'b1); chk("rr1", out, 7); chk("rr1_multi", multi, 1);
      step(8'b1000_0001, 1'b1, 1'b1); chk("rr2", out, 0);
      step(8'b1000_0001, 1'b1, 1'b1); chk("rr3", out, 7);

      // Backpressure holds result and counter.
      step(8'b0010_0000, 1'b1, 1'b1); chk("bp_out", out, 5);
      c0 = cnt;
      for (int i = 0; i < 4; i++) begin
         step(8'($urandom), 1'($urandom), 1'b0);
         chk("bp_hold_out", out, 5); chk("bp_hold_valid", valid, 1); chk("bp_hold_cnt", cnt, c0);
      end
      step(8'h00, 1'b1, 1'b1);
      chk("bp_release_cnt", cnt, (c0 + 1) % 256); chk("bp_release_valid", valid, 0);

      // Pointer now 6: wrap through 7 back to 0, then idle.
      step(8'b0100_0000, 1'b1, 1'b1); chk("wrap6", out, 6);
      step(8'b1000_0001, 1'b1, 1'b1); chk("wrap7", out, 7);
      step(8'h00, 1'b1, 1'b1);        chk("wrap_idle", valid, 0);
      step(8'b1000_0001, 1'b1, 1'b1); chk("wrap0", out, 0);

      // Enable low blocks captures; resumes at pointer 1.
      step(8'hFF, 1'b0, 1'b1); chk("en0_a", valid, 0);
      step(8'hFF, 1'b0, 1'b1); chk("en0_b", valid, 0); chk("en0_out_hold", out, 0);
      step(8'hFF, 1'b1, 1'b1); chk("en1_out", out, 1); chk("en1_valid", valid, 1);

      // Randomized traffic, checked against the model each cycle.
      for (int i = 0; i < 2000; i++) begin
         logic [7:0] r;
         r = ($urandom_range(0, 3) == 0) ? 8'd0 :
             ($urandom_range(0, 1) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'($urandom);
         step(r, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
      end

      // Counter wrap after 256 handshakes.
      do_reset();
      for (int i = 0; i < 255; i++) step(8'hFF, 1'b1, 1'b1);
      chk("cnt_255", cnt, 254);
      step(8'hFF, 1'b1, 1'b1); chk("cnt_255b", cnt, 255);
      step(8'hFF, 1'b1, 1'b1); chk("cnt_wrap", cnt, 0);
      step(8'hFF, 1'b1, 1'b0); chk("pre_rst_valid", valid, 1);

      // Asynchronous reset between edges discards the pending result.
      req = 8'h00; en = 1'b0; rdy = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", out, 0); chk("arst_valid", valid, 0);
      chk("arst_multi", multi, 0); chk("arst_cnt", cnt, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_cnt", cnt, 0);
      step(8'b0000_0001, 1'b1, 1'b1); chk("post_rst_out", out, 0); chk("post_rst_valid", valid, 1);

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
